// File: rtl/kernel_arb_pkg.sv
// rtl/kernel_arb_pkg.sv - shared types and constants for the kernel multiply arbiter
//
// Contents:
//   STREAMW_DEF  default operand/result width
//   TAG_MAX_W    tag index width wide enough for the largest supported NREQ (16)
//   PERF_W       width of each performance counter
//   kc_tag_t     {valid, idx} record carried through the leaf latency pipeline
package kernel_arb_pkg;

    localparam int STREAMW_DEF = 32;
    localparam int TAG_MAX_W   = 4;
    localparam int PERF_W      = 32;

    // idx is sized for the largest requester count so one type serves every
    // NREQ; unused upper bits are always zero.
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] idx;
    } kc_tag_t;

endpackage

// File: rtl/kernel_rr_arbiter.sv
// rtl/kernel_rr_arbiter.sv - round-robin grant selector with rotating pointer
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-low reset; pointer returns to NREQ-1
//   req      NREQ request vector (already qualified by eligibility)
//   enable   grants allowed this cycle (leaf ready and out of reset)
//   advance  a grant is taken at this edge; pointer moves to idx
//   grant    one-hot grant, zero when nothing granted
//   idx      index of the granted requester, zero when nothing granted
module kernel_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int TAGW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [TAGW-1:0] idx
);

    logic [TAGW-1:0] ptr;

    // Search upward from ptr+1 with wrap-around; the last granted requester
    // is visited last, so it has lowest priority next time.
    always_comb begin
        int   cand;
        logic found;
        cand  = 0;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        if (enable) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = (int'(ptr) + k) % NREQ;
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    idx         = TAGW'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= TAGW'(NREQ - 1);
        end else if (advance) begin
            ptr <= idx;
        end
    end

endmodule

// File: rtl/kernel_mul_arbiter.sv
// rtl/kernel_mul_arbiter.sv - shares one pipelined multiply leaf among NREQ requester streams
//
// Optional feature macro: KC_ARB_PERF_CNT_EN (adds perf_busy / perf_grants counters)
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready       per-requester operand handshake (req_ready one-hot or zero)
//   req_a, req_b              packed operands, requester i in slice i
//   res_valid/res_ready       per-requester one-entry result slot handshake
//   res_data                  packed results, requester i in slice i
//   mul_ivalid/mul_iready     leaf input handshake
//   mul_in1, mul_in2          leaf operands
//   mul_oready                leaf output ready, tied high
//   mul_ovalid, mul_out       leaf result
//   perf_busy                 (macro only) cycles with mul_ivalid=1
//   perf_grants               (macro only) packed per-requester grant counts
module kernel_mul_arbiter
    import kernel_arb_pkg::*;
#(
    parameter  int STREAMW = STREAMW_DEF,
    parameter  int NREQ    = 4,
    parameter  int LAT     = 1,
    localparam int TAGW    = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*STREAMW-1:0] req_a,
    input  logic [NREQ*STREAMW-1:0] req_b,
    output logic [NREQ-1:0]         res_valid,
    input  logic [NREQ-1:0]         res_ready,
    output logic [NREQ*STREAMW-1:0] res_data,
    output logic                    mul_ivalid,
    input  logic                    mul_iready,
    output logic [STREAMW-1:0]      mul_in1,
    output logic [STREAMW-1:0]      mul_in2,
    output logic                    mul_oready,
    input  logic                    mul_ovalid,
    input  logic [STREAMW-1:0]      mul_out
`ifdef KC_ARB_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]       perf_busy,
    output logic [NREQ*PERF_W-1:0]  perf_grants
`endif
);

    logic [NREQ-1:0] inflight;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic [TAGW-1:0] gnt_idx;
    logic            gnt_any;
    kc_tag_t         tag_pipe [LAT];
    kc_tag_t         tail;

    // One operation per requester at a time; a full result slot also blocks,
    // so a slot can never be set and cleared on the same edge.
    assign elig = req_valid & ~res_valid & ~inflight;

    kernel_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .enable  (mul_iready & rst),
        .advance (gnt_any),
        .grant   (grant),
        .idx     (gnt_idx)
    );

    assign gnt_any    = |grant;
    assign req_ready  = grant;
    assign mul_ivalid = gnt_any;
    // With no grant gnt_idx is zero, so the operands show slice 0 (don't-care).
    assign mul_in1    = req_a[int'(gnt_idx)*STREAMW +: STREAMW];
    assign mul_in2    = req_b[int'(gnt_idx)*STREAMW +: STREAMW];
    assign mul_oready = 1'b1;

    // Tag pipeline tracks which requester owns each leaf stage; it shifts
    // every cycle because the leaf never stalls its output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < LAT; s++) tag_pipe[s] <= '0;
        end else begin
            tag_pipe[0].valid <= gnt_any;
            tag_pipe[0].idx   <= TAG_MAX_W'(gnt_idx);
            for (int s = 1; s < LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    assign tail = tag_pipe[LAT-1];

    // A valid tail tag always retires its inflight bit; the result is only
    // captured when the leaf actually presents it. An ovalid without a valid
    // tag (stale leaf output after reset) is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight  <= '0;
            res_valid <= '0;
            res_data  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (res_valid[i] && res_ready[i]) res_valid[i] <= 1'b0;
                if (tail.valid && tail.idx == TAG_MAX_W'(i)) begin
                    inflight[i] <= 1'b0;
                    if (mul_ovalid) begin
                        res_valid[i]                   <= 1'b1;
                        res_data[i*STREAMW +: STREAMW] <= mul_out;
                    end
                end
                if (grant[i]) inflight[i] <= 1'b1;
            end
        end
    end

`ifdef KC_ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_busy   <= '0;
            perf_grants <= '0;
        end else begin
            if (mul_ivalid) perf_busy <= perf_busy + PERF_W'(1);
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    perf_grants[i*PERF_W +: PERF_W] <= perf_grants[i*PERF_W +: PERF_W] + PERF_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_kernel_mul_arbiter.sv
// tb/tb_kernel_mul_arbiter.sv - directed self-checking bench for kernel_mul_arbiter
module tb_kernel_mul_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   res_valid;
    logic [N-1:0]   res_ready = '0;
    logic [N*W-1:0] res_data;
    logic           mul_ivalid;
    logic           mul_iready = 1'b1;
    logic [W-1:0]   mul_in1, mul_in2;
    logic           mul_oready;
    logic           mul_ovalid;
    logic [W-1:0]   mul_out;
`ifdef KC_ARB_PERF_CNT_EN
    logic [31:0]    perf_busy;
    logic [N*32-1:0] perf_grants;
`endif

    always #5 clk = ~clk;

    // LAT=1 leaf model; deliberately not reset so a stale result can appear.
    logic         lf_ovalid = 1'b0;
    logic [W-1:0] lf_out    = '0;
    always @(posedge clk) begin
        lf_ovalid <= mul_ivalid & mul_iready;
        lf_out    <= mul_in1 * mul_in2;
    end
    assign mul_ovalid = lf_ovalid;
    assign mul_out    = lf_out;

    kernel_mul_arbiter #(.STREAMW(W), .NREQ(N), .LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .mul_ivalid (mul_ivalid),
        .mul_iready (mul_iready),
        .mul_in1    (mul_in1),
        .mul_in2    (mul_in2),
        .mul_oready (mul_oready),
        .mul_ovalid (mul_ovalid),
        .mul_out    (mul_out)
`ifdef KC_ARB_PERF_CNT_EN
        ,
        .perf_busy  (perf_busy),
        .perf_grants(perf_grants)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    function automatic logic [W-1:0] rd(input int i);
        return res_data[i*W +: W];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gq [8];
        int ng;
        bit seen [N];
        int nseen;
        int to;
        int cnt;

        // ---- reset state
        cyc(); cyc();
        check("rst_req_ready", req_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_ivalid", mul_ivalid, 0);
        check("rst_oready", mul_oready, 1);
        check("rst_res_data", res_data, 0);
        rst = 1'b1;
        cyc();

        // ---- single request: 7*6 on requester 2
        set_ops(2, 7, 6);
        res_ready = '0;
        req_valid = 4'b0100;
        #1;
        check("t1_req_ready", req_ready, 4'b0100);
        check("t1_ivalid", mul_ivalid, 1);
        check("t1_in1", mul_in1, 7);
        check("t1_in2", mul_in2, 6);
        cyc();
        check("t1_inflight_ready", req_ready, 0);
        check("t1_early_valid", res_valid, 0);
        cyc();
        check("t1_res_valid", res_valid, 4'b0100);
        check("t1_res_data", rd(2), 42);
        cyc(); cyc();
        check("t1_res_hold", res_valid, 4'b0100);
        check("t1_blocked", req_ready, 0);
        res_ready = 4'b0100;
        cyc();
        check("t1_consumed", res_valid, 0);
        check("t1_regrant", req_ready, 4'b0100);
        req_valid = '0;
        res_ready = 4'b1111;
        cyc(); cyc(); cyc();

        // ---- fairness: all valid, results consumed immediately
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_ops(i, W'(i + 1), 10);
            seen[i] = 1'b0;
        end
        req_valid = 4'b1111;
        res_ready = 4'b1111;
        ng = 0;
        #1;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            if (mul_ivalid) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) gq[ng] = i;
                ng++;
            end
            for (int i = 0; i < N; i++) begin
                if (res_valid[i] && !seen[i]) begin
                    check("fair_res", rd(i), 64'((i + 1) * 10));
                    seen[i] = 1'b1;
                end
            end
            cyc();
        end
        check("fair_ngrants", ng, 8);
        for (int k = 0; k < ng; k++) check("fair_order", gq[k], k % N);
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) begin
                if (res_valid[i] && !seen[i]) begin
                    check("fair_res", rd(i), 64'((i + 1) * 10));
                    seen[i] = 1'b1;
                end
            end
            cyc();
        end
        nseen = 0;
        for (int i = 0; i < N; i++) nseen += int'(seen[i]);
        check("fair_all_results", nseen, N);

        // ---- back-pressure: pointer left at 1, then leaf not ready
        do_reset();
        req_valid = 4'b0010;
        #1;
        check("bp_pre_grant", req_ready, 4'b0010);
        cyc();
        req_valid = '0;
        cyc(); cyc(); cyc();
        mul_iready = 1'b0;
        req_valid  = 4'b1111;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("bp_stalled", {req_ready, mul_ivalid}, 0);
            cyc();
        end
        mul_iready = 1'b1;
        #1;
        check("bp_resume", req_ready, 4'b0100);
        req_valid = '0;
        cyc(); cyc(); cyc(); cyc();

        // ---- truncation: (2^16+3)*2^16 keeps only the low 32 bits
        res_ready = '0;
        set_ops(0, 32'h0001_0003, 32'h0001_0000);
        req_valid = 4'b0001;
        #1;
        cyc();
        req_valid = '0;
        to = 0;
        while (!res_valid[0] && to < 10) begin
            cyc();
            to++;
        end
        check("trunc_valid", res_valid[0], 1);
        check("trunc_data", rd(0), 32'h0003_0000);
        res_ready = 4'b1111;
        cyc(); cyc();

        // ---- async reset right after a grant
        res_ready = '0;
        set_ops(3, 3, 4);
        req_valid = 4'b1000;
        #1;
        cyc();
        req_valid = '0;
        cyc();
        check("rm_pre_res", res_valid, 4'b1000);
        set_ops(1, 9, 9);
        set_ops(0, 5, 6);
        req_valid = 4'b1010;
        #1;
        check("rm_pre_grant", req_ready, 4'b0010);
        cyc();
        req_valid = 4'b1011;
        rst = 1'b0;
        #1;
        check("rm_res_cleared", res_valid, 0);
        check("rm_ready_low", req_ready, 0);
        check("rm_ivalid_low", mul_ivalid, 0);
        #3;
        rst = 1'b1;
        #1;
        check("rm_first_grant", req_ready, 4'b0001);
        cyc();
        check("rm_stale_ignored", res_valid, 0);
        check("rm_stale_data", rd(1), 0);
        req_valid = '0;
        cyc();
        check("rm_new_res", res_valid, 4'b0001);
        check("rm_new_data", rd(0), 30);
        res_ready = 4'b1111;
        cyc(); cyc(); cyc();

`ifdef KC_ARB_PERF_CNT_EN
        // ---- perf counters: 10 grants to requester 1, 3 to requester 3
        do_reset();
        res_ready = 4'b1111;
        cnt = 0;
        req_valid = 4'b0010;
        #1;
        for (int c = 0; c < 100 && cnt < 10; c++) begin
            if (req_ready[1]) cnt++;
            cyc();
        end
        req_valid = '0;
        cyc(); cyc(); cyc();
        cnt = 0;
        req_valid = 4'b1000;
        #1;
        for (int c = 0; c < 100 && cnt < 3; c++) begin
            if (req_ready[3]) cnt++;
            cyc();
        end
        req_valid = '0;
        cyc(); cyc(); cyc();
        check("perf_g1", perf_grants[1*32 +: 32], 10);
        check("perf_g3", perf_grants[3*32 +: 32], 3);
        check("perf_g0", perf_grants[0 +: 32], 0);
        check("perf_busy", perf_busy, 13);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kernel_mul_arbiter.md
Name: kernel_mul_arbiter

Overview:
- Shares one pipelined multiply leaf node (kernel_C_kc_vout-style leaf unit) among NREQ requester streams.
- Arbitrates operand pairs round-robin, drives the leaf's ivalid/iready handshake, and tracks a request tag through the leaf latency.
- Steers each result into a per-requester one-entry result slot.
- Sits between NREQ producer streams and one shared leaf instance inside a TyBEC-generated compute node.

Parameters:
- STREAMW, 32, operand/result width; must match the leaf.
- NREQ, 4, number of requesters, 2..16.
- LAT, 1, leaf latency in cycles from ivalid accept to ovalid; must be at least 1.
- TAGW, $clog2(NREQ), width of the requester index (derived, local).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  NREQ*STREAMW  packed first operands; requester i occupies slice i.
- req_b  in  NREQ*STREAMW  packed second operands.
- res_valid  out  NREQ  per-requester result valid.
- res_ready  in  NREQ  per-requester result consume.
- res_data  out  NREQ*STREAMW  packed results.
- mul_ivalid  out  1  to leaf ivalid.
- mul_iready  in  1  from leaf iready.
- mul_in1  out  STREAMW  to leaf in1_s0.
- mul_in2  out  STREAMW  to leaf in2_s0.
- mul_oready  out  1  to leaf oready; constant 1.
- mul_ovalid  in  1  from leaf ovalid.
- mul_out  in  STREAMW  from leaf out1_s0.

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is asynchronous and active-low.
  - rst=0 clears the RR pointer (last granted = NREQ-1, so requester 0 has first priority), inflight[], tag pipeline valid bits, res_valid[] and res_data.
  - Combinational outputs are driven 0 while any input of theirs is 0. mul_oready is 1 always.
- Eligibility:
  - elig[i] = req_valid[i] & ~res_valid[i] & ~inflight[i].
  - Worst-case rate is one operation in flight per requester. No result can be dropped, because the leaf never stalls (mul_oready=1).
- Grant (combinational):
  - When mul_iready=1, the lowest eligible index searching upward from pointer+1, with wrap-around, is granted.
  - For that grant: req_ready[g]=1, mul_ivalid=1, mul_in1/mul_in2 = slice g of req_a/req_b.
  - With no eligible requester, or mul_iready=0: req_ready=0, mul_ivalid=0, and the operand outputs hold the slice-0 mux value (don't-care).
- On a grant edge:
  - pointer <= g.
  - inflight[g] <= 1.
  - The tag pipeline stage 0 captures {valid=1, g}.
  - The tag pipeline is LAT stages deep and shifts every cycle.
- Return path:
  - When mul_ovalid=1 and the last tag stage is valid with index t: res_data[t] <= mul_out, res_valid[t] <= 1, inflight[t] <= 0.
  - mul_ovalid=1 with an invalid tag (e.g. after reset) is ignored.
  - An invalid tag with mul_ovalid=0 is normal idle.
  - A valid tag with mul_ovalid=0 is a protocol error: the tag is dropped and inflight is cleared.
- Result slot:
  - res_valid[i]&res_ready[i] clears res_valid[i] at the edge.
  - Simultaneous set and clear on the same slot is impossible, because inflight blocks it.
- Latency: accept edge to res_valid high is LAT+1 cycles. For LAT=1, a grant in cycle n gives res_valid in cycle n+2.
- Reset mid-operation: everything in flight is discarded. No res_valid asserts for pre-reset requests.
- Data width: the product is truncated to STREAMW by the leaf; the arbiter does no arithmetic.

Optional Feature:
- Macro KC_ARB_PERF_CNT_EN.
- When defined:
  - Adds output perf_busy (32 bits): counts cycles with mul_ivalid=1.
  - Adds output perf_grants (NREQ*32 bits): per-requester grant counts.
  - Counters wrap at 2^32, clear on reset, and increment on the same edge as the grant.
- When undefined: neither the ports nor the logic exist, and behaviour is otherwise identical.

Decomposition:
- Shared package kernel_arb_pkg:
  - STREAMW default.
  - Tag typedef {logic valid; logic [TAGW-1:0] idx}.
  - Perf counter width constant 32.
- One sub-module, kernel_rr_arbiter:
  - Inputs: NREQ request vector, enable (mul_iready), advance strobe.
  - Outputs: one-hot grant and index.
  - Holds the rotating pointer.
- The top level holds the tag pipeline, inflight bits, result slots and muxes.

Test Plan:
- Single request: NREQ=4, LAT=1, req 2 with a=7, b=6, all res_ready=0.
  -> req_ready[2] pulses one cycle; res_valid[2]=1 with res_data slice 2 = 42 two cycles later and held; req 2 blocked until res_ready[2].
- Fairness: all 4 requesters valid continuously, res_ready=1.
  -> grant order 0,1,2,3,0,...; each result matches its own operands (a=i+1, b=10 gives 10,20,30,40).
- Back-pressure: mul_iready=0 for 5 cycles with requests pending.
  -> no req_ready, no mul_ivalid; granting resumes at the pointer+1 index.
- Wrap/truncation: STREAMW=8, a=0x10, b=0x20.
  -> res_data=0x00.
- Async reset mid-flight: assert rst=0 for half a cycle right after a grant.
  -> all res_valid and req_ready go 0 immediately, the stale mul_ovalid is ignored, and the first grant after release goes to requester 0.
- With KC_ARB_PERF_CNT_EN: 10 grants to requester 1 and 3 to requester 3.
  -> perf_grants slice 1 = 10, slice 3 = 3, perf_busy = 13.
